// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: CPU data-bus store/readback signals seen by the UART transmitter.
interface uart_tx_mmio_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_enable;
  logic        mem_write;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output byte_enable, output mem_write, input rdata);
  modport slave  (input addr, input wdata, input byte_enable, input mem_write, output rdata);
endinterface

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter. Stores to BASE_ADDR queue a byte in the
// TX FIFO; bytes are serialised 8N1 on txd. STATUS (BASE_ADDR+4) is read back on rdata.
// Optional: define UART_PARITY_EN for 8E1 framing (even parity bit between data and stop).
module uart_tx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          resetn,
  uart_tx_mmio_if.slave bus,
  output logic          txd,
  output logic          tx_busy
);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef UART_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t              state, state_nxt;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          shift, shift_nxt;
  logic                txd_nxt;
  logic                baud_done;
  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count, count_nxt;
  logic                fifo_empty, fifo_full;
  logic                overflow;
  logic [7:0]          head;
  logic                wr_data_c, clr_ovf_c, push_c, pop_c, tx_busy_nxt_c;
  logic                unused_bits;
`ifdef UART_PARITY_EN
  logic                parity;
`endif

  assign unused_bits = ^{bus.wdata[31:8], bus.byte_enable[3:1]};

  // Store decode: only byte lane 0 carries register data
  assign wr_data_c = bus.mem_write && (bus.addr == BASE_ADDR) && bus.byte_enable[0];
  assign clr_ovf_c = bus.mem_write && (bus.addr == STATUS_ADDR) && bus.byte_enable[0] && bus.wdata[3];

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign head       = mem[rd_ptr];
  assign baud_done  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  // A full FIFO still accepts a push when the serialiser pops on the same edge
  assign push_c     = wr_data_c && (!fifo_full || pop_c);

  // FIFO occupancy after this edge
  always_comb begin
    count_nxt = count;
    if (push_c && !pop_c)      count_nxt = count + CNT_W'(1);
    else if (pop_c && !push_c) count_nxt = count - CNT_W'(1);
  end

  assign tx_busy_nxt_c = (state_nxt != S_IDLE) || (count_nxt != '0);

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // FSM next state, FIFO pop, shift register load/shift and next line level
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    shift_nxt = shift;
    txd_nxt   = 1'b1;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop_c     = 1'b1;
          shift_nxt = head;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (baud_done) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (baud_done) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end else begin
            shift_nxt = {1'b0, shift[7:1]};
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (baud_done) state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            pop_c     = 1'b1;
            shift_nxt = head;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    case (state_nxt)
      S_START:  txd_nxt = 1'b0;
      S_DATA:   txd_nxt = shift_nxt[0];
`ifdef UART_PARITY_EN
      S_PARITY: txd_nxt = parity;
`endif
      default:  txd_nxt = 1'b1;
    endcase
  end

  // Serialiser datapath: baud counter, bit index, shift register, registered line/busy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
`ifdef UART_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      baud_cnt <= (state == S_IDLE || baud_done) ? '0 : baud_cnt + BAUD_W'(1);
      if (state == S_DATA && baud_done) bit_idx <= bit_idx + 3'd1;
      shift    <= shift_nxt;
      txd      <= txd_nxt;
      tx_busy  <= tx_busy_nxt_c;
`ifdef UART_PARITY_EN
      if (pop_c) parity <= ^head;
`endif
    end
  end

  // FIFO pointers, occupancy and sticky overflow (clear beats a same-cycle set)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      if (clr_ovf_c)                                overflow <= 1'b0;
      else if (wr_data_c && fifo_full && !pop_c)    overflow <= 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= bus.wdata[7:0];
  end

  // STATUS readback, one cycle behind the live flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) bus.rdata <= 32'd0;
    else         bus.rdata <= {19'd0, 9'(count), overflow, tx_busy, fifo_full, fifo_empty};
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: randomized self-checking bench for uart_tx_mmio with a serial-line receiver model.
module tb_uart_tx_mmio;
  localparam int unsigned L = 4;
  localparam int unsigned D = 4;
  localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef UART_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned F = L * NBITS;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic txd, tx_busy;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] rx_q[$];
  logic mon_en = 1'b0;
  int rx_err = 0;

  uart_tx_mmio_if bus();

  uart_tx_mmio #(.CLKS_PER_BIT(L), .FIFO_DEPTH(D), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .txd(txd), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // Expected line level for bit slot i of a frame carrying d
  function automatic logic frame_bit(input logic [7:0] d, input int unsigned i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (i == NBITS - 1) return 1'b1;
    return ^d;
  endfunction

  // Serial receiver: detects a start bit, samples mid-bit, queues decoded bytes
  initial begin : monitor
    logic [7:0] b;
    logic p, s;
    forever begin
      @(posedge clk); #1;
      if (resetn && txd == 1'b0) begin
        repeat (L/2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (L) @(posedge clk); #1;
          b[i] = txd;
        end
`ifdef UART_PARITY_EN
        repeat (L) @(posedge clk); #1;
        p = txd;
`else
        p = ^b;
`endif
        repeat (L) @(posedge clk); #1;
        s = txd;
        if (mon_en) begin
          rx_q.push_back(b);
          if (s !== 1'b1 || p !== ^b) rx_err++;
        end
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.addr = a; bus.wdata = d; bus.byte_enable = be; bus.mem_write = 1'b1;
    @(posedge clk); #1;
    bus.mem_write = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int t = 0;
    while (tx_busy === 1'b1 && t < limit) begin
      @(posedge clk); #1;
      t++;
    end
    n_tests++;
    if (t >= limit) begin n_fail++; $display("FAIL %s_timeout busy=%b after %0d clks", tag, tx_busy, t); end
    repeat (L) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (txd !== 1'b1)     begin n_fail++; $display("FAIL reset_txd got=%b exp=1", txd); end
    n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    n_tests++; if (bus.rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (bus.rdata !== 32'h1) begin n_fail++; $display("FAIL reset_status_idle got=%h exp=00000001", bus.rdata); end
  endtask

  // One byte into an idle block: exact txd waveform and busy timing
  task automatic run_single(input logic [7:0] d);
    bus_write(BASE, {24'($urandom), d}, 4'b0001);
    n_tests++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_rise d=%h got=%b exp=1", d, tx_busy); end
    for (int k = 0; k < int'(F); k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (txd !== frame_bit(d, k / L)) begin
        n_fail++; $display("FAIL single_txd d=%h clk=%0d got=%b exp=%b", d, k, txd, frame_bit(d, k / L));
      end
      if (k == int'(F) - 1) begin
        n_tests++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_hold d=%h got=%b exp=1", d, tx_busy); end
      end
    end
    @(posedge clk); #1;
    n_tests++; if (txd !== 1'b1)     begin n_fail++; $display("FAIL single_txd_end d=%h got=%b exp=1", d, txd); end
    n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall d=%h got=%b exp=0", d, tx_busy); end
  endtask

  task automatic test_single();
    run_single(8'h55);
    run_single(8'($urandom));
    run_single(8'($urandom));
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [3];
    int exp_cnt;
    int k;
    b[0] = 8'h41; b[1] = 8'h42; b[2] = 8'h43;
    exp_cnt = 3 - 1;
    bus_write(BASE, {24'd0, b[0]}, 4'b0001);
    bus_write(BASE, {24'd0, b[1]}, 4'b0001);
    k = 0;
    n_tests++; if (txd !== frame_bit(b[0], 0)) begin n_fail++; $display("FAIL b2b_txd clk=0 got=%b exp=0", txd); end
    bus_write(BASE, {24'd0, b[2]}, 4'b0001);
    k = 1;
    n_tests++; if (txd !== frame_bit(b[0], 0)) begin n_fail++; $display("FAIL b2b_txd clk=1 got=%b exp=0", txd); end
    for (k = 2; k < 3 * int'(F); k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (txd !== frame_bit(b[k / F], (k % F) / L)) begin
        n_fail++; $display("FAIL b2b_txd clk=%0d got=%b exp=%b", k, txd, frame_bit(b[k / F], (k % F) / L));
      end
      if (k == 2) begin
        n_tests++;
        if (bus.rdata[12:4] !== 9'(exp_cnt)) begin
          n_fail++; $display("FAIL b2b_count got=%0d exp=%0d", bus.rdata[12:4], exp_cnt);
        end
      end
    end
    @(posedge clk); #1;
    n_tests++; if (tx_busy !== 1'b0 || txd !== 1'b1) begin
      n_fail++; $display("FAIL b2b_end busy=%b txd=%b exp busy=0 txd=1", tx_busy, txd);
    end
  endtask

  task automatic test_ignored();
    bus_write(BASE, {24'd0, 8'($urandom)}, 4'b0010);
    bus_write(BASE + 32'd8, {24'd0, 8'($urandom)}, 4'b0001);
    bus_write(BASE + 32'(4 * $urandom_range(3, 64)), 32'($urandom), 4'b1111);
    bus_write(BASE + 32'd4, 32'h0000_00F7, 4'b0001);
    for (int k = 0; k < 2 * int'(F); k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (txd !== 1'b1 || tx_busy !== 1'b0 || bus.rdata !== 32'h1) begin
        n_fail++; $display("FAIL ignored clk=%0d txd=%b busy=%b rdata=%h exp txd=1 busy=0 rdata=00000001", k, txd, tx_busy, bus.rdata);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] v [6];
    int accepted, buffered;
    logic [31:0 ] exp_status;
    for (int i = 0; i < 6; i++) v[i] = 8'($urandom);
    rx_q.delete(); rx_err = 0;
    for (int i = 0; i < 6; i++) bus_write(BASE, {24'($urandom), v[i]}, 4'b0001);
    accepted = (6 < int'(D) + 1) ? 6 : int'(D) + 1;
    buffered = accepted - 1;
    exp_status = {19'd0, 9'(buffered), 1'b1, 1'b1, (buffered == int'(D)), (buffered == 0)};
    @(posedge clk); #1;
    n_tests++; if (bus.rdata !== exp_status) begin n_fail++; $display("FAIL ovf_status got=%h exp=%h", bus.rdata, exp_status); end
    bus_write(BASE + 32'd4, 32'h0000_0008, 4'b0001);
    @(posedge clk); #1;
    exp_status[3] = 1'b0;
    n_tests++; if (bus.rdata !== exp_status) begin n_fail++; $display("FAIL ovf_clear got=%h exp=%h", bus.rdata, exp_status); end
    wait_idle("ovf", 8 * int'(F));
    n_tests++; if (rx_q.size() != accepted) begin n_fail++; $display("FAIL ovf_rx_count got=%0d exp=%0d", rx_q.size(), accepted); end
    for (int i = 0; i < accepted && i < rx_q.size(); i++) begin
      n_tests++; if (rx_q[i] !== v[i]) begin n_fail++; $display("FAIL ovf_rx_byte idx=%0d got=%h exp=%h", i, rx_q[i], v[i]); end
    end
    n_tests++; if (rx_err != 0) begin n_fail++; $display("FAIL ovf_framing got=%0d exp=0", rx_err); end
  endtask

  task automatic test_random_burst();
    for (int it = 0; it < 3; it++) begin
      logic [7:0] exp_q[$];
      int n;
      n = $urandom_range(2, D);
      rx_q.delete(); rx_err = 0;
      for (int i = 0; i < n; i++) begin
        logic [7:0] d;
        d = 8'($urandom);
        exp_q.push_back(d);
        bus_write(BASE, {24'($urandom), d}, 4'b0001 | 4'($urandom_range(0, 7) << 1));
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      wait_idle("burst", (n + 2) * int'(F));
      n_tests++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL burst_rx_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        n_tests++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL burst_rx_byte idx=%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
      end
      n_tests++; if (rx_err != 0 || bus.rdata !== 32'h1) begin
        n_fail++; $display("FAIL burst_end framing=%0d rdata=%h exp framing=0 rdata=00000001", rx_err, bus.rdata);
      end
    end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    run_single(8'h07);
    run_single(8'h03);
    run_single(8'($urandom));
  endtask
`endif

  task automatic test_reset_midframe();
    mon_en = 1'b0;
    bus_write(BASE, 32'h0000_00A5, 4'b0001);
    repeat (3 * L + 1) @(posedge clk);
    @(negedge clk); resetn = 1'b0; #1;
    n_tests++; if (txd !== 1'b1)        begin n_fail++; $display("FAIL midreset_txd got=%b exp=1", txd); end
    n_tests++; if (bus.rdata !== 32'd0) begin n_fail++; $display("FAIL midreset_rdata got=%h exp=0", bus.rdata); end
    n_tests++; if (tx_busy !== 1'b0)    begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", tx_busy); end
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (bus.rdata !== 32'h1 || txd !== 1'b1) begin
      n_fail++; $display("FAIL midreset_after rdata=%h txd=%b exp rdata=00000001 txd=1", bus.rdata, txd);
    end
    run_single(8'h0F);
  endtask

  initial begin
    bus.addr = '0; bus.wdata = '0; bus.byte_enable = '0; bus.mem_write = 1'b0;
    test_reset();
    mon_en = 1'b1;
    test_single();
    test_back_to_back();
    test_ignored();
    test_overflow();
    test_random_burst();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the CPU data bus, downstream of the core's store path.
- Consumes the store address/data/byte-enable/write-strobe the core produces.
- Buffers bytes in a small FIFO and serialises them 8N1 on txd to drive the board TX pin.
- Provides a status register the core can read through the data-bus read mux.

Parameters:
CLKS_PER_BIT, 234, clk cycles per UART bit (27 MHz / 115200); legal range 2..65535
FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256
BASE_ADDR, 32'h8000_0000, DATA register address; STATUS register is BASE_ADDR+4

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
addr  input  32  data-bus byte address (CPU alu_result)
wdata  input  32  store data
byte_enable  input  4  store byte lanes
mem_write  input  1  store strobe; one-clk pulse per store
rdata  output  32  STATUS readback, registered
txd  output  1  serial out, idle high
tx_busy  output  1  high while a frame is on the line or FIFO non-empty

Behaviour:
Reset (async, resetn=0):
- txd=1, tx_busy=0, rdata=0, FIFO emptied, overflow=0, FSM=IDLE, baud counter=0, bit index=0.
- Mid-frame reset truncates the frame; txd returns high immediately.

Stores, sampled on posedge clk with mem_write=1:
- addr==BASE_ADDR and byte_enable[0]=1: push wdata[7:0].
  - If FIFO full and no pop this cycle: byte dropped, overflow sticky bit set.
- addr==BASE_ADDR+4 and byte_enable[0]=1 and wdata[3]=1: clear overflow. Clear wins over a same-cycle set.
- Any other address or byte lane: ignored.

FIFO:
- Pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
- Simultaneous push and pop: both occur, count unchanged. Push is accepted even when full, because a slot frees the same cycle.

STATUS register (rdata updated every clk with this value, 1-cycle latency):
- [0] fifo_empty
- [1] fifo_full
- [2] tx_busy
- [3] overflow
- [12:4] count
- others 0

FSM states: IDLE, START, DATA, STOP.
- IDLE: when FIFO non-empty, pop into shift register, go to START. txd falls on the same edge.
- START: txd=0 for CLKS_PER_BIT clks, then DATA.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT clks, then STOP.
- STOP: txd=1 for CLKS_PER_BIT clks. Then pop the next byte directly into START if FIFO non-empty (no idle gap), else go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and resets on every state/bit change.

Latency:
- Store at edge N into an empty idle block: txd low after edge N+1.
- Frame length is 10*CLKS_PER_BIT clks.

tx_busy = (state!=IDLE) | ~fifo_empty.

Optional Feature:
UART_PARITY_EN
- Defined: an extra PARITY state between DATA and STOP transmits even parity (XOR of the 8 data bits) for CLKS_PER_BIT clks. Format is 8E1; frame is 11*CLKS_PER_BIT clks.
- Undefined: no PARITY state; 8N1, 10*CLKS_PER_BIT clks.

Test Plan:
1. CLKS_PER_BIT=4, store 0x55 to BASE_ADDR -> txd low after edge N+1, then 1,0,1,0,1,0,1,0, then stop 1, each 4 clks; tx_busy drops 40 clks after edge N+1.
2. Store 0x41, 0x42, 0x43 back-to-back -> three contiguous frames, no idle gap between stop and next start; STATUS count reads 2 one clk after the third store.
3. FIFO_DEPTH=4, 6 stores during the first frame -> one byte popped, 4 buffered, the 6th dropped; STATUS[3]=1, [1]=1. Store 0x8 to BASE_ADDR+4 -> STATUS[3]=0.
4. Store with byte_enable=4'b0010, or to BASE_ADDR+8 -> no frame, count stays 0, txd stays 1.
5. Assert resetn=0 mid-DATA of 0xA5 -> txd=1 and STATUS=0 immediately. After release, a new store 0x0F transmits cleanly.
6. With UART_PARITY_EN, store 0x07 -> parity bit 1, frame 44 clks. Store 0x03 -> parity bit 0.
